// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO.
// Provides a true full flag, an occupancy count, programmable almost-full and
// almost-empty thresholds, and sticky overflow/underflow error flags.
// Compile-time option SYNC_FIFO_FWFT_EN selects first-word-fall-through reads:
// the head word is shown on data_out while the FIFO is not empty, and rd consumes it.
// With the macro undefined, data_out is a register that loads on each accepted read.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   rd,
  output logic [DATA_W-1:0]      data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  // The pointers carry one extra MSB, the wrap bit. It tells full apart from
  // empty, so all DEPTH entries can hold data.
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_CNT   = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_CNT   = PTR_W'(AE_LEVEL);

  // Reject parameter sets that are not legal during elaboration.
  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_W must be >= 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("sync_fifo_param: require 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc, wr_acc;

  // Occupancy and flags are decoded from the registered pointers.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read needs data to be present. A write needs a free slot, or a read
  // accepted in the same cycle that frees one.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  // Next-state logic: advance the pointers and set the sticky error flags.
  always_comb begin
    // NOTE: every output of this block gets a default first. Any path that left
    // one unassigned would make synthesis infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc)       wr_ptr_d    = wr_ptr_q + PTR_W'(1);
    if (rd_acc)       rd_ptr_d    = rd_ptr_q + PTR_W'(1);
    if (wr && !wr_acc) overflow_d  = 1'b1;
    if (rd && !rd_acc) underflow_d = 1'b1;
  end

  // Control state registers. Reset takes priority over any wr or rd in the same cycle.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples its inputs before any of them updates at this edge.
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array. It is written only on an accepted write.
  always_ff @(posedge clock) begin
    // NOTE: the memory is left out of reset on purpose. Reset moves the pointers,
    // so old contents can never be read, and the array stays a plain RAM.
    if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // First-word-fall-through: show the head word while data is present, otherwise 0.
  always_comb begin
    data_out = '0;
    if (!empty) data_out = mem_q[rd_ptr_q[ADDR_W-1:0]];
  end
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;

  // Registered read: load the head word on an accepted read, otherwise hold.
  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc) data_out_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
  end

  // Read data register. Reset clears it to 0.
  always_ff @(posedge clock) begin
    if (reset) data_out_q <= '0;
    else       data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: self-checking bench for sync_fifo_param with default parameters.
// A queue-based reference model predicts every output after every clock edge.
// Directed sequences cover fill, drain, pointer wrap, simultaneous access and reset.
// A randomized phase with several read/write biases follows.
// The bench follows SYNC_FIFO_FWFT_EN to predict data_out in the matching read mode.
module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int AF     = 28;
  localparam int AE     = 4;
  localparam int PTR_W  = 6;

  logic              clock = 1'b0;
  logic              reset, wr, rd;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              full, empty, almost_full, almost_empty, overflow, underflow;
  logic [PTR_W-1:0]  count;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr          (wr),
    .data_in     (data_in),
    .rd          (rd),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: a queue of stored words plus the registered read data and sticky flags.
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] model_do;
  logic              model_ov, model_un;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    int n;
    logic [DATA_W-1:0] exp_do;
    n = model_q.size();
`ifdef SYNC_FIFO_FWFT_EN
    exp_do = (n > 0) ? model_q[0] : '0;
`else
    exp_do = model_do;
`endif
    check("count",        32'(count),        32'(n));
    check("empty",        32'(empty),        32'(n == 0));
    check("full",         32'(full),         32'(n == DEPTH));
    check("almost_full",  32'(almost_full),  32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("overflow",     32'(overflow),     32'(model_ov));
    check("underflow",    32'(underflow),    32'(model_un));
    check("data_out",     32'(data_out),     32'(exp_do));
  endtask

  // Drive one cycle of inputs, step the model at the edge, then check the outputs 1 time unit later.
  task automatic cycle(input logic r, input logic w, input logic [DATA_W-1:0] d, input logic rr);
    logic ra, wa;
    reset = r; wr = w; data_in = d; rd = rr;
    @(posedge clock);
    if (r) begin
      model_q.delete();
      model_do = '0;
      model_ov = 1'b0;
      model_un = 1'b0;
    end else begin
      ra = rr && (model_q.size() > 0);
      wa = w && ((model_q.size() < DEPTH) || ra);
      if (ra) model_do = model_q.pop_front();
      if (wa) model_q.push_back(d);
      if (w && !wa) model_ov = 1'b1;
      if (rr && !ra) model_un = 1'b1;
    end
    #1;
    compare_all();
  endtask

  initial begin
    model_do = '0; model_ov = 1'b0; model_un = 1'b0;
    reset = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0;

    // Reset state.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_data_out", 32'(data_out), 32'h0);

    // Fill with 0x00..0x1F, then try a write to the full FIFO.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    check("fill_count", 32'(count), 32'd32);
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    check("fill_overflow", 32'(overflow), 32'd1);

    // Drain 32 words, then issue one read too many.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_underflow", 32'(underflow), 32'd1);

    // Wrap-around: two rounds of 20 writes and 20 reads carry the pointers past DEPTH.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 8'((rep == 0 ? 8'h40 : 8'h60) + i), 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("wrap_count", 32'(count), 32'd0);

    // Full FIFO with rd and wr together: the write is accepted and 0xEE comes out last.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'hEE, 1'b1);
    check("simul_full_count", 32'(count), 32'd32);
    check("simul_full_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("simul_full_last", 32'(data_out), 32'hEE);
`endif

    // Empty FIFO with rd and wr together: the write lands and the read is rejected.
    cycle(1'b0, 1'b1, 8'h11, 1'b1);
    check("simul_empty_count", 32'(count), 32'd1);
    check("simul_empty_unf", 32'(underflow), 32'd1);

    // Reset mid-operation at count=10 with overflow set.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 22; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("mid_count", 32'(count), 32'd10);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("mid_rst_data", 32'(data_out), 32'h0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    cycle(1'b0, 1'b1, 8'h3C, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_head", 32'(data_out), 32'h3C);
`endif
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("mid_readback", 32'(data_out), 32'h3C);
`endif

    // FWFT case: 0x5A shows up on data_out with no rd.
    cycle(1'b0, 1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic in phases biased toward filling, draining and balance; rare resets.
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      case (ph % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      for (int c = 0; c < 400; c++) begin
        cycle($urandom_range(0, 299) == 0,
              $urandom_range(0, 99) < wp,
              8'($urandom),
              $urandom_range(0, 99) < rp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
